score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Parameters
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000: the number of clk cycles each digit stays active (1 ms per digit at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1: when 1, leading zeros are blanked; digit 0 is never blanked.

Interface
REQ-003 clk  input  1  system clock; one clock domain; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 value  input  14  unsigned binary value to display.
REQ-006 load  input  1  single-cycle request to capture value.
REQ-007 busy  output  1  high while a binary-to-BCD conversion runs.
REQ-008 an  output  4  active-low anode enables; an[0] is the rightmost digit.
REQ-009 seg  output  7  active-low cathodes; seg[0]=ca through seg[6]=cg.
REQ-010 dp  output  1  decimal point; held at 1 (off).

Function
REQ-011 The block SHALL sample load only while busy=0; a load while busy=1 SHALL be ignored, not queued.
REQ-012 On an accepted load, the block SHALL capture value and saturate it: any value above 9999 becomes 9999.
REQ-013 Conversion SHALL use sequential shift-add-3 (double dabble) with one bit per cycle: 14 cycles, MSB first.
REQ-014 Conversion SHALL use a two-state FSM:
- IDLE -> CONV on an accepted load.
- CONV -> IDLE after the 14th shift.
REQ-015 busy SHALL be 1 in exactly the 14 cycles following the load edge.
REQ-016 The displayed BCD register (4 nibbles) SHALL update atomically on the edge that ends CONV; it SHALL never show a partial result.
REQ-017 A load accepted on the same edge that ends CONV is impossible (busy=1 then); a load in the first cycle with busy=0 SHALL be accepted.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On each wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL be the one-hot-low image of the index; exactly one an bit SHALL be 0 at any time outside reset.
REQ-020 seg SHALL use the standard active-low encoding for 0..9 (for example 0 = 7'b1000000, 8 = 7'b0000000).
REQ-021 Nibble values 10..15 and blanked digits SHALL drive seg = 7'b1111111.
REQ-022 With BLANK_LZ=1, digit i (i>0) SHALL be blanked when it and all more-significant digits are zero.
REQ-023 an and seg SHALL be registered: one cycle of latency from index or BCD change to the pins. Anode and cathode SHALL change on the same edge, with no ghosting cycle.

Reset
REQ-024 While rst=1, the block SHALL hold the following values:
- busy=0, FSM=IDLE
- displayed BCD=0000, index=0, refresh counter=0
- an=4'b1111, seg=7'b1111111, dp=1
REQ-025 On the first edge after rst falls, an SHALL become 4'b1110 and seg SHALL become 7'b1000000.
REQ-026 A reset during CONV SHALL abort the conversion and discard its partial result.

Structure
REQ-027 A shared package SHALL hold the following:
- segment encoding constants SEG_0..SEG_9 and SEG_BLANK
- MAX_DISPLAY=9999
- the FSM state typedef
REQ-028 The binary-to-BCD engine SHALL be a sub-module named bin2bcd_seq, with ports clk, rst, start, bin[13:0], busy, done, bcd[15:0].
REQ-029 The scan logic and segment encoding SHALL stay in score_display. Total RTL SHALL be 150-250 lines.

Verification
REQ-030 The bench SHALL run with REFRESH_DIV=4 and cover these scenarios:
- Reset release -> an=1110 and seg=1000000 one edge later; index advances every 4 cycles; an cycles 1110, 1101, 1011, 0111.
- load with value=1234 -> busy high 14 cycles; then digits 3..0 decode to 1, 2, 3, 4 with the 1/2/3/4 segment patterns.
- load with value=12000 -> display 9999; load with value=16383 -> display 9999.
- load with value=7 and BLANK_LZ=1 -> digits 3..1 show 1111111 and digit 0 shows 7; with BLANK_LZ=0, digits 3..1 show 1000000. load with value=0 -> digit 0 shows 0.
- load with value=5678, then a second load with value=1111 at busy cycle 5 -> the second load is ignored and the display shows 5678.
- load with value=4321, then rst asserted at busy cycle 7 -> busy=0, display 0000, an=1111 during reset, and no 4321 ever appears.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants and types for the four-digit score display.
// Segment patterns are active-low, bit 0 = ca ... bit 6 = cg.
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam int          CONV_BITS   = 14;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, MSB first.
// bcd/done present the finished result during the last CONV cycle.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  state_t      state_q, state_d;
  logic [13:0] sh_q, sh_d;
  logic [14:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] adj;
  logic [15:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Inputs are <= 9999, so the thousands digit is at most 4 before the
  // final shift and never needs adjusting; its top bit is still zero.
  always_comb begin
    adj     = {acc_q[14:12], add3(acc_q[11:8]),
               add3(acc_q[7:4]), add3(acc_q[3:0])};
    shifted = {adj, sh_q[13]};
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = {sh_q[12:0], 1'b0};
        acc_d = shifted[14:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(CONV_BITS - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CONV);
  assign bcd  = shifted;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment score display with saturating
// binary input, sequential BCD conversion and leading-zero blanking.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [13:0]   bin_sat;
  logic          start;
  logic          conv_done;
  logic [15:0]   conv_bcd;

  logic [15:0]   disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          blank;

  assign start   = load & ~busy;
  assign bin_sat = (value > MAX_DISPLAY) ? MAX_DISPLAY : value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin_sat),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    nib   = disp_q[3:0];
    blank = 1'b0;
    unique case (idx_q)
      2'd0: nib = disp_q[3:0];
      2'd1: begin
        nib   = disp_q[7:4];
        blank = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = disp_q[11:8];
        blank = (disp_q[15:8] == 8'd0);
      end
      2'd3: begin
        nib   = disp_q[15:12];
        blank = (disp_q[15:12] == 4'd0);
      end
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = (blank && (BLANK_LZ != 0)) ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display with REFRESH_DIV=4, covering
// both leading-zero blanking settings via two instances.
`timescale 1ns/1ps
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        busy, busy_n;
  logic [3:0]  an, an_n;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .an(an), .seg(seg), .dp(dp)
  );

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_nlz (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_n), .an(an_n), .seg(seg_n), .dp(dp_n)
  );

  function automatic logic [15:0] model_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] t[10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int i,
                                          input bit lz);
    logic [15:0] hi;
    hi = b >> (4 * i);
    if (lz && i > 0 && hi == 16'd0) return 7'b1111111;
    return ref_seg(b[4*i +: 4]);
  endfunction

  // Drive at a negedge: load is seen by the next posedge.
  task automatic drive_load(input int v, input bit expect_accept);
    value = 14'(v);
    load  = 1'b1;
    if (expect_accept) sb.push_back(model_bcd(v));
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic capture(output logic [6:0] s[4], output logic [6:0] t[4],
                         output bit ok);
    logic [3:0] seen;
    int i;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      s[k] = 'x;
      t[k] = 'x;
    end
    @(negedge clk);
    for (int c = 0; c < 24 && seen != 4'hf; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: i = 0;
        4'b1101: i = 1;
        4'b1011: i = 2;
        4'b0111: i = 3;
        default: i = -1;
      endcase
      if (i >= 0) begin
        s[i] = seg;
        t[i] = seg_n;
        seen[i] = 1'b1;
      end
    end
    ok = (seen == 4'hf);
  endtask

  task automatic test_reset;
    logic [3:0] seq[4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, an, seg, dp} !== {1'b0, 4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: busy=%b an=%b seg=%b dp=%b, need 0 1111 1111111 1",
               busy, an, seg, dp);
    end
    checks++;
    if ({an_n, dp_n} !== {4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold_nlz: an=%b dp=%b, need 1111 1", an_n, dp_n);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      errors++;
      $display("FAIL reset_release: an=%b seg=%b, need 1110 1000000", an, seg);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (an !== seq[k]) begin
        errors++;
        $display("FAIL scan_step%0d: an=%b, need %b", k, an, seq[k]);
      end
    end
  endtask

  task automatic test_convert(input int v);
    int n;
    logic [15:0] e;
    logic [6:0] s[4], t[4];
    bit ok;
    drive_load(v, 1'b1);
    wait_idle(n);
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL busy_len_%0d: %0d cycles, need 14", v, n);
    end
    e = sb.pop_front();
    capture(s, t, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_%0d: not all anodes seen", v);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(e, i, 1'b1)) begin
        errors++;
        $display("FAIL conv_%0d_d%0d: seg=%b, need %b", v, i, s[i],
                 exp_seg(e, i, 1'b1));
      end
      checks++;
      if (t[i] !== exp_seg(e, i, 1'b0)) begin
        errors++;
        $display("FAIL conv_nlz_%0d_d%0d: seg=%b, need %b", v, i, t[i],
                 exp_seg(e, i, 1'b0));
      end
    end
  endtask

  task automatic test_ignored_load;
    int n;
    logic [15:0] e;
    logic [6:0] s[4], t[4];
    bit ok;
    drive_load(5678, 1'b1);
    repeat (4) @(negedge clk);
    drive_load(1111, 1'b0);
    wait_idle(n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL ignore_busy_len: %0d remaining cycles, need 9", n);
    end
    e = sb.pop_front();
    capture(s, t, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_scan: ok=%b busy=%b, need 1 0", ok, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(e, i, 1'b1)) begin
        errors++;
        $display("FAIL ignore_d%0d: seg=%b, need %b", i, s[i],
                 exp_seg(e, i, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] e;
    logic [6:0] s[4], t[4];
    bit ok;
    drive_load(9, 1'b0);
    wait_idle(n);
    drive_load(8765, 1'b1);
    wait_idle(n);
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL b2b_busy_len: %0d cycles, need 14", n);
    end
    e = sb.pop_front();
    capture(s, t, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(e, i, 1'b1)) begin
        errors++;
        $display("FAIL b2b_d%0d: seg=%b, need %b", i, s[i],
                 exp_seg(e, i, 1'b1));
      end
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    logic [15:0] e;
    logic [6:0] s[4], t[4];
    bit ok;
    drive_load(4321, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, an, seg} !== {1'b0, 4'b1111, 7'b1111111}) begin
      errors++;
      $display("FAIL abort_reset: busy=%b an=%b seg=%b, need 0 1111 1111111",
               busy, an, seg);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || seg === 7'b0011001 || seg === 7'b0110000 ||
          seg === 7'b0100100 || seg === 7'b1111001) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_leak: %0d cycles busy or showing 4321 digits, need 0", bad);
    end
    e = model_bcd(0);
    capture(s, t, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(e, i, 1'b1)) begin
        errors++;
        $display("FAIL abort_d%0d: seg=%b, need %b", i, s[i],
                 exp_seg(e, i, 1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert(1234);
    test_convert(12000);
    test_convert(16383);
    test_convert(7);
    test_convert(0);
    test_ignored_load();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries, need 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
